// File: rtl/fluxo_jogo_pkg.sv
// Shared types and constants for the round-based chess-move trainer datapath.
package fluxo_jogo_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        PREPARA   = 3'd1,
        ESPERA    = 3'd2,
        COMPARA   = 3'd3,
        RESULTADO = 3'd4,
        FIM       = 3'd5
    } estado_t;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the Fibonacci LFSR: shift left, feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/gerador_alvo_lfsr.sv
// Target-square generator: free-running LFSR, reduction to the board, and
// a nudge of the column so the same square never comes up twice in a row.
module gerador_alvo_lfsr
    import fluxo_jogo_pkg::*;
#(
    parameter int unsigned COORD_W    = 4,
    parameter int unsigned BOARD_SIZE = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    output logic [COORD_W-1:0] linha,
    output logic [COORD_W-1:0] coluna
);

    localparam logic [COORD_W-1:0] MASCARA = COORD_W'(BOARD_SIZE - 1);

    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [COORD_W-1:0] linha_q, linha_d;
    logic [COORD_W-1:0] coluna_q, coluna_d;
    logic [COORD_W-1:0] linha_nova_c, coluna_nova_c;

    // Next LFSR value and candidate target with repeat avoidance.
    always_comb begin
        lfsr_d        = lfsr_next(lfsr_q);
        linha_d       = linha_q;
        coluna_d      = coluna_q;
        linha_nova_c  = lfsr_q[COORD_W-1:0] & MASCARA;
        coluna_nova_c = lfsr_q[2*COORD_W-1:COORD_W] & MASCARA;
        if (carrega) begin
            linha_d  = linha_nova_c;
            coluna_d = coluna_nova_c;
            if (linha_nova_c == linha_q && coluna_nova_c == coluna_q) begin
                coluna_d = (coluna_nova_c + COORD_W'(1)) & MASCARA;
            end
        end
    end

    // LFSR and target registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            linha_q  <= '0;
            coluna_q <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            linha_q  <= linha_d;
            coluna_q <= coluna_d;
        end
    end

    assign linha  = linha_q;
    assign coluna = coluna_q;

endmodule

// File: rtl/fluxo_dados_rodadas.sv
// Round-based game datapath and controller for the chess-move trainer.
// Optional macro BONUS_TEMPO_EN: fast hits (timer above 3/4 of the round) score 2.
module fluxo_dados_rodadas
    import fluxo_jogo_pkg::*;
#(
    parameter int unsigned COORD_W    = 4,
    parameter int unsigned BOARD_SIZE = 8,
    parameter int unsigned TIMER_MAX  = 30000,
    parameter int unsigned TIMER_W    = 15,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned MAX_ERROS  = 3,
    parameter int unsigned ROUNDS     = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic [COORD_W-1:0]             jogadaLinha,
    input  logic [COORD_W-1:0]             jogadaColuna,
    input  logic                           temJogada,
    output logic [COORD_W-1:0]             linhaEsperada,
    output logic [COORD_W-1:0]             colunaEsperada,
    output logic [SCORE_W-1:0]             pontos,
    output logic [$clog2(MAX_ERROS+1)-1:0] erros,
    output logic [$clog2(ROUNDS+1)-1:0]    rodada,
    output logic                           acertou,
    output logic                           errou,
    output logic                           timeout,
    output logic                           jogando,
    output logic                           fim_jogo,
    output logic [COORD_W-1:0]             db_linha,
    output logic [COORD_W-1:0]             db_coluna,
    output logic [2:0]                     db_estado
);

    localparam int unsigned ERR_W  = $clog2(MAX_ERROS + 1);
    localparam int unsigned ROD_W  = $clog2(ROUNDS + 1);
    localparam int unsigned SOMA_W = SCORE_W + 1;
    localparam logic [SCORE_W-1:0] PONTOS_MAX = '1;

    estado_t            estado_q, estado_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SCORE_W-1:0] pontos_q, pontos_d;
    logic [ERR_W-1:0]   erros_q, erros_d;
    logic [ROD_W-1:0]   rodada_q, rodada_d;
    logic [COORD_W-1:0] mov_linha_q, mov_linha_d;
    logic [COORD_W-1:0] mov_coluna_q, mov_coluna_d;
    logic               tem_ant_q, tem_ant_d;
    logic               acertou_q, acertou_d;
    logic               errou_q, errou_d;
    logic               timeout_q, timeout_d;
    logic               jogando_q, jogando_d;
    logic               fim_q, fim_d;

    logic               carrega_c;
    logic               borda_c;
    logic               acerto_c;
    logic [SOMA_W-1:0]  soma_c;
    logic [SCORE_W-1:0] pontos_sat_c;

    gerador_alvo_lfsr #(
        .COORD_W    (COORD_W),
        .BOARD_SIZE (BOARD_SIZE)
    ) u_gerador (
        .clock   (clock),
        .reset   (reset),
        .carrega (carrega_c),
        .linha   (linhaEsperada),
        .coluna  (colunaEsperada)
    );

    assign borda_c  = temJogada & ~tem_ant_q;
    assign acerto_c = (mov_linha_q == linhaEsperada) && (mov_coluna_q == colunaEsperada);

`ifdef BONUS_TEMPO_EN
    localparam logic [TIMER_W-1:0] LIMIAR_BONUS = TIMER_W'(3 * TIMER_MAX / 4);
    // Timer still holds its value from the capture cycle while in COMPARA.
    assign soma_c = {1'b0, pontos_q} +
                    ((timer_q > LIMIAR_BONUS) ? SOMA_W'(2) : SOMA_W'(1));
`else
    assign soma_c = {1'b0, pontos_q} + SOMA_W'(1);
`endif
    assign pontos_sat_c = soma_c[SOMA_W-1] ? PONTOS_MAX : soma_c[SCORE_W-1:0];

    // Next-state and datapath update logic.
    always_comb begin
        estado_d     = estado_q;
        timer_d      = timer_q;
        pontos_d     = pontos_q;
        erros_d      = erros_q;
        rodada_d     = rodada_q;
        mov_linha_d  = mov_linha_q;
        mov_coluna_d = mov_coluna_q;
        tem_ant_d    = temJogada;
        acertou_d    = 1'b0;
        errou_d      = 1'b0;
        timeout_d    = 1'b0;
        carrega_c    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    pontos_d     = '0;
                    erros_d      = '0;
                    rodada_d     = '0;
                    mov_linha_d  = '0;
                    mov_coluna_d = '0;
                    estado_d     = PREPARA;
                end
            end
            PREPARA: begin
                carrega_c = 1'b1;
                timer_d   = TIMER_W'(TIMER_MAX - 1);
                estado_d  = ESPERA;
            end
            ESPERA: begin
                if (borda_c) begin
                    mov_linha_d  = jogadaLinha;
                    mov_coluna_d = jogadaColuna;
                    estado_d     = COMPARA;
                end else if (timer_q == '0) begin
                    timeout_d = 1'b1;
                    erros_d   = erros_q + ERR_W'(1);
                    estado_d  = RESULTADO;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            COMPARA: begin
                if (acerto_c) begin
                    acertou_d = 1'b1;
                    pontos_d  = pontos_sat_c;
                end else begin
                    errou_d = 1'b1;
                    erros_d = erros_q + ERR_W'(1);
                end
                estado_d = RESULTADO;
            end
            RESULTADO: begin
                rodada_d = rodada_q + ROD_W'(1);
                if (erros_q == ERR_W'(MAX_ERROS) || rodada_d == ROD_W'(ROUNDS)) begin
                    estado_d = FIM;
                end else begin
                    estado_d = PREPARA;
                end
            end
            FIM: begin
                if (iniciar) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
        jogando_d = (estado_d == PREPARA) || (estado_d == ESPERA) ||
                    (estado_d == COMPARA) || (estado_d == RESULTADO);
        fim_d     = (estado_d == FIM);
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            timer_q      <= '0;
            pontos_q     <= '0;
            erros_q      <= '0;
            rodada_q     <= '0;
            mov_linha_q  <= '0;
            mov_coluna_q <= '0;
            tem_ant_q    <= 1'b0;
            acertou_q    <= 1'b0;
            errou_q      <= 1'b0;
            timeout_q    <= 1'b0;
            jogando_q    <= 1'b0;
            fim_q        <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            timer_q      <= timer_d;
            pontos_q     <= pontos_d;
            erros_q      <= erros_d;
            rodada_q     <= rodada_d;
            mov_linha_q  <= mov_linha_d;
            mov_coluna_q <= mov_coluna_d;
            tem_ant_q    <= tem_ant_d;
            acertou_q    <= acertou_d;
            errou_q      <= errou_d;
            timeout_q    <= timeout_d;
            jogando_q    <= jogando_d;
            fim_q        <= fim_d;
        end
    end

    assign pontos    = pontos_q;
    assign erros     = erros_q;
    assign rodada    = rodada_q;
    assign acertou   = acertou_q;
    assign errou     = errou_q;
    assign timeout   = timeout_q;
    assign jogando   = jogando_q;
    assign fim_jogo  = fim_q;
    assign db_linha  = mov_linha_q;
    assign db_coluna = mov_coluna_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_fluxo_dados_rodadas.sv
// Self-checking bench for fluxo_dados_rodadas: table of rounds plus directed sequences.
module tb_fluxo_dados_rodadas;

    localparam int TM      = 40;
    localparam int K_HIT   = 0;
    localparam int K_LATE  = 1;
    localparam int K_TO    = 2;
`ifdef BONUS_TEMPO_EN
    localparam int INC = 2;
`else
    localparam int INC = 1;
`endif

    logic       clk = 1'b0;
    logic       reset, iniciar, temJogada;
    logic [3:0] jogadaLinha, jogadaColuna;
    logic [3:0] linhaEsperada, colunaEsperada;
    logic [3:0] pontos;
    logic [1:0] erros;
    logic [4:0] rodada;
    logic       acertou, errou, timeout, jogando, fim_jogo;
    logic [3:0] db_linha, db_coluna;
    logic [2:0] db_estado;

    int n_total = 0;
    int n_bad   = 0;

    fluxo_dados_rodadas #(
        .COORD_W(4), .BOARD_SIZE(8), .TIMER_MAX(TM), .TIMER_W(6),
        .SCORE_W(4), .MAX_ERROS(3), .ROUNDS(20)
    ) dut (
        .clock(clk), .reset(reset), .iniciar(iniciar),
        .jogadaLinha(jogadaLinha), .jogadaColuna(jogadaColuna), .temJogada(temJogada),
        .linhaEsperada(linhaEsperada), .colunaEsperada(colunaEsperada),
        .pontos(pontos), .erros(erros), .rodada(rodada),
        .acertou(acertou), .errou(errou), .timeout(timeout),
        .jogando(jogando), .fim_jogo(fim_jogo),
        .db_linha(db_linha), .db_coluna(db_coluna), .db_estado(db_estado)
    );

    always #5 clk = ~clk;

    // Reference LFSR and expected target, stepped alongside the design.
    logic [15:0] lfsr_m;
    logic [3:0]  exp_l, exp_c, nl, nc;
    always_comb begin
        nl = {1'b0, lfsr_m[2:0]};
        nc = {1'b0, lfsr_m[6:4]};
        if (nl == exp_l && nc == exp_c) nc = (nc + 4'd1) & 4'd7;
    end
    always @(posedge clk) begin
        if (reset) begin
            lfsr_m <= 16'hACE1;
            exp_l  <= 4'd0;
            exp_c  <= 4'd0;
        end else begin
            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            if (db_estado == 3'd1) begin
                exp_l <= nl;
                exp_c <= nc;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (db_estado !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 32'(db_estado), 32'(s));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pontos"}, 32'(pontos), 0);
        check({tag, "_erros"}, 32'(erros), 0);
        check({tag, "_rodada"}, 32'(rodada), 0);
        check({tag, "_pulsos"}, 32'({acertou, errou, timeout}), 0);
        check({tag, "_flags"}, 32'({jogando, fim_jogo}), 0);
        check({tag, "_mov"}, 32'({db_linha, db_coluna}), 0);
        check({tag, "_alvo"}, 32'({linhaEsperada, colunaEsperada}), 0);
        check({tag, "_estado"}, 32'(db_estado), 0);
    endtask

    task automatic start_from_idle();
        iniciar = 1'b1;
        @(negedge clk);
        check("start_prepara", 32'(db_estado), 1);
        check("start_jogando", 32'(jogando), 1);
        check("start_zerado", 32'({pontos, erros, rodada}), 0);
        iniciar = 1'b0;
    endtask

    task automatic start_from_fim();
        iniciar = 1'b1;
        @(negedge clk);
        check("fim_para_ocioso", 32'(db_estado), 0);
        check("ocioso_flags", 32'({jogando, fim_jogo}), 0);
        @(negedge clk);
        check("reinicio_prepara", 32'(db_estado), 1);
        check("reinicio_zerado", 32'({pontos, erros, rodada}), 0);
        iniciar = 1'b0;
    endtask

    task automatic run_round(input int kind, input bit ok, input bit e_acc, input bit e_err,
                             input bit e_to, input int e_pts, input int e_ers,
                             input int e_rod, input bit e_fim);
        wait_state(3'd2, 12);
        check("alvo_linha", 32'(linhaEsperada), 32'(exp_l));
        check("alvo_coluna", 32'(colunaEsperada), 32'(exp_c));
        jogadaLinha  = exp_l;
        jogadaColuna = ok ? exp_c : (exp_c ^ 4'd1);
        if (kind == K_HIT) begin
            temJogada = 1'b1;
            @(negedge clk);
            check("compara_estado", 32'(db_estado), 3);
            check("mov_registrado", 32'({db_linha, db_coluna}), 32'({jogadaLinha, jogadaColuna}));
            @(negedge clk);
        end else begin
            repeat (TM - 1) @(negedge clk);
            check("antes_timeout", 32'({timeout, db_estado}), 32'({1'b0, 3'd2}));
            if (kind == K_LATE) begin
                temJogada = 1'b1;
                @(negedge clk);
                check("tardia_compara", 32'({timeout, db_estado}), 32'({1'b0, 3'd3}));
            end
            @(negedge clk);
        end
        check("pulso_acertou", 32'(acertou), 32'(e_acc));
        check("pulso_errou", 32'(errou), 32'(e_err));
        check("pulso_timeout", 32'(timeout), 32'(e_to));
        check("pontos", 32'(pontos), 32'(e_pts));
        check("erros", 32'(erros), 32'(e_ers));
        check("resultado_estado", 32'(db_estado), 4);
        temJogada = 1'b0;
        @(negedge clk);
        check("rodada", 32'(rodada), 32'(e_rod));
        check("fim_jogo", 32'(fim_jogo), 32'(e_fim));
        check("pulso_unico", 32'({acertou, errou, timeout}), 0);
    endtask

    typedef struct {
        int kind; bit ok; bit acc; bit err; bit to;
        int pts; int ers; int rod; bit fim;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{K_HIT,  1, 1, 0, 0, INC, 0, 1, 0};
        tbl[1] = '{K_HIT,  0, 0, 1, 0, INC, 1, 2, 0};
        tbl[2] = '{K_HIT,  0, 0, 1, 0, INC, 2, 3, 0};
        tbl[3] = '{K_HIT,  0, 0, 1, 0, INC, 3, 4, 1};
        tbl[4] = '{K_TO,   1, 0, 0, 1, 0,   1, 1, 0};
        tbl[5] = '{K_LATE, 1, 1, 0, 0, 1,   1, 2, 0};
        tbl[6] = '{K_LATE, 0, 0, 1, 0, 1,   2, 3, 0};
        tbl[7] = '{K_TO,   1, 0, 0, 1, 1,   3, 4, 1};

        reset = 1'b1; iniciar = 1'b0; temJogada = 1'b0;
        jogadaLinha = '0; jogadaColuna = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("ocioso_espera", 32'(db_estado), 0);

        // Games 1 and 2: hit/miss sequence to the error limit, then timeouts and late moves.
        start_from_idle();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                repeat (3) @(negedge clk);
                check("fim_segura", 32'({erros, rodada, fim_jogo, db_estado}),
                      32'({2'd3, 5'd4, 1'b1, 3'd5}));
                start_from_fim();
            end
            run_round(tbl[i].kind, tbl[i].ok, tbl[i].acc, tbl[i].err, tbl[i].to,
                      tbl[i].pts, tbl[i].ers, tbl[i].rod, tbl[i].fim);
        end

        // Game 3: twenty fast hits; score saturates and the round limit ends the game.
        start_from_fim();
        for (int i = 0; i < 20; i++) begin
            run_round(K_HIT, 1, 1, 0, 0, (INC * (i + 1) > 15) ? 15 : INC * (i + 1),
                      0, i + 1, i == 19);
        end
        check("saturado_estado", 32'(db_estado), 5);

        // Game 4: edge outside ESPERA ignored, then reset mid-ESPERA with temJogada high.
        start_from_fim();
        run_round(K_HIT, 1, 1, 0, 0, INC, 0, 1, 0);
        temJogada = 1'b1;
        repeat (4) @(negedge clk);
        check("borda_prepara_ignorada", 32'(db_estado), 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset_meio");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("pos_reset_ocioso", 32'(db_estado), 0);
        start_from_idle();
        wait_state(3'd2, 4);
        repeat (5) @(negedge clk);
        check("sem_borda_espuria", 32'({db_estado, erros}), 32'({3'd2, 2'd0}));
        temJogada = 1'b0;
        @(negedge clk);
        run_round(K_HIT, 1, 1, 0, 0, INC, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fluxo_dados_rodadas.md
Name: fluxo_dados_rodadas

Overview:
Parametrised round-based game datapath with its own controller, for the chess-move trainer. Each round it does the following:
- generates a target square;
- runs a per-round countdown;
- captures the player's move on a rising edge of temJogada and judges it hit, miss or timeout;
- updates score, error count and round count.

The game ends after ROUNDS rounds or MAX_ERROS errors. It sits between the board-input decoder and the display/top FSM.

Parameters:
COORD_W, 4, bits per coordinate (row and column).
BOARD_SIZE, 8, squares per side; power of two, at most 2**COORD_W.
TIMER_MAX, 30000, countdown cycles per round.
TIMER_W, 15, countdown width; must satisfy 2**TIMER_W > TIMER_MAX.
SCORE_W, 8, score width.
MAX_ERROS, 3, errors (misses plus timeouts) that end the game; at least 1.
ROUNDS, 16, rounds per game; at least 1.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high; returns everything to OCIOSO.
iniciar  in  1  level; sampled in OCIOSO and FIM to start a new game.
jogadaLinha  in  COORD_W  player row.
jogadaColuna  in  COORD_W  player column.
temJogada  in  1  level "move present"; only its rising edge counts.
linhaEsperada  out  COORD_W  current target row.
colunaEsperada  out  COORD_W  current target column.
pontos  out  SCORE_W  score.
erros  out  $clog2(MAX_ERROS+1)  error count.
rodada  out  $clog2(ROUNDS+1)  rounds completed.
acertou  out  1  one-cycle pulse on hit.
errou  out  1  one-cycle pulse on miss.
timeout  out  1  one-cycle pulse on countdown expiry.
jogando  out  1  high in PREPARA, ESPERA, COMPARA and RESULTADO.
fim_jogo  out  1  high in FIM.
db_linha  out  COORD_W  registered move row.
db_coluna  out  COORD_W  registered move column.
db_estado  out  3  state encoding.

Behaviour:
- Reset:
  - State goes to OCIOSO.
  - Counters, registers and pulses are zero.
  - Target outputs are 0.
  - LFSR loads seed 16'hACE1.
  - Edge-detector history is cleared, so a temJogada held high through reset gives no edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle while not in reset, including in OCIOSO.
- OCIOSO: when iniciar=1, clear pontos, erros, rodada and the move registers, then go to PREPARA.
- PREPARA (1 cycle):
  - Target row = lfsr[COORD_W-1:0] mod BOARD_SIZE.
  - Target column = lfsr[2*COORD_W-1:COORD_W] mod BOARD_SIZE.
  - If the new target equals the previous target, column = (column+1) mod BOARD_SIZE.
  - Load timer with TIMER_MAX-1, then go to ESPERA.
- ESPERA:
  - Timer decrements by 1 each cycle.
  - On a temJogada rising edge (temJogada=1 this cycle, 0 last cycle): register jogadaLinha and jogadaColuna, then go to COMPARA.
  - Else if timer==0: pulse timeout, erros+1, go to RESULTADO.
  - If the edge and timer==0 happen in the same cycle, the move wins and there is no timeout.
  - Edges outside ESPERA are ignored.
- COMPARA (1 cycle), comparing the registered move with the target:
  - Equal: pulse acertou; pontos+1, saturating at 2**SCORE_W-1.
  - Not equal: pulse errou; erros+1.
  - Go to RESULTADO.
- RESULTADO (1 cycle):
  - rodada+1.
  - If erros==MAX_ERROS or rodada+1==ROUNDS, go to FIM; otherwise go to PREPARA.
- FIM:
  - All counters hold; fim_jogo=1.
  - When iniciar=1, go to OCIOSO, then start on the next cycle if iniciar is still high.
- Latency:
  - Move edge to acertou/errou pulse: 2 cycles.
  - Entry to ESPERA to timeout pulse: TIMER_MAX cycles.
- Reset asserted in any state overrides everything on the next edge.

Optional Feature:
BONUS_TEMPO_EN. When defined, a hit registered while the timer is above 3*TIMER_MAX/4 adds 2 points (saturating) instead of 1. When undefined, every hit adds 1 and the comparison logic is absent.

Decomposition:
Package fluxo_jogo_pkg holds:
- the state enum OCIOSO=0, PREPARA=1, ESPERA=2, COMPARA=3, RESULTADO=4, FIM=5;
- the LFSR seed and tap constants.

One sub-module, gerador_alvo_lfsr, contains the LFSR, the modulo reduction and the repeat-avoid logic. Its interface is clock, reset, carrega, linha, coluna.

Test Plan:
1. Reset, then iniciar=1 for 1 cycle. Expect OCIOSO→PREPARA→ESPERA, db_estado=2, jogando=1, and target rows/columns below 8.
2. In ESPERA, drive the move equal to linhaEsperada/colunaEsperada and raise temJogada. Expect acertou pulse 2 cycles later, pontos=1, rodada=1.
3. Drive a wrong square. Expect errou, erros=1. Repeat twice more: expect erros=3, fim_jogo=1, db_estado=5 after the third RESULTADO.
4. Hold temJogada low in ESPERA. Expect timeout exactly TIMER_MAX cycles after ESPERA entry and erros+1. Also raise temJogada in the cycle timer==0: expect no timeout, and a judged move instead.
5. Run 16 correct rounds with SCORE_W=4 and ROUNDS=20. Expect pontos to saturate at 15. With BONUS_TEMPO_EN, an immediate hit gives pontos=2.
6. Assert reset mid-ESPERA with temJogada held high. Expect all outputs 0, OCIOSO, and no spurious edge detected after restart.
